// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes a raw pin, debounces it and emits
// press / release / long-press pulses plus a wrapping press counter.
`timescale 1ns/1ps
module btn_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 6000000,
  parameter int ACTIVE_HIGH       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic                   btn_pol;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  state_t                 state_reg;
  logic [DB_W-1:0]        db_cnt_reg;
  logic [HOLD_W-1:0]      hold_cnt_reg;
  logic                   long_done_reg;

  // Polarity is fixed before the first flop so reset means "not pressed".
  assign btn_pol = (ACTIVE_HIGH != 0) ? btn_in : ~btn_in;
  assign s       = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_pol};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RELEASED;
      db_cnt_reg       <= '0;
      hold_cnt_reg     <= '0;
      long_done_reg    <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= 8'd0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (s) begin
            state_reg  <= DB_PRESS;
            db_cnt_reg <= '0;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_reg <= RELEASED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg     <= PRESSED;
            btn_level     <= 1'b1;
            press_pulse   <= 1'b1;
            press_count   <= press_count + 8'd1;
            hold_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_reg  <= DB_RELEASE;
            db_cnt_reg <= '0;
          end else if (!long_done_reg) begin
            // Hold counter freezes once the long pulse has fired.
            if (hold_cnt_reg == HOLD_LAST) begin
              long_press_pulse <= 1'b1;
              long_done_reg    <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          // A bounce back to pressed resumes the paused hold count.
          if (s) begin
            state_reg <= PRESSED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg     <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce / long-press windows.
`timescale 1ns/1ps
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  int vectors = 0;
  int errors = 0;
  int cyc, n_press, n_rel, n_long, level_hi, overlap;
  int last_press_cyc, last_rel_cyc, last_long_cyc;

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(20), .ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    cyc = -1; n_press = 0; n_rel = 0; n_long = 0; level_hi = 0; overlap = 0;
    last_press_cyc = -1; last_rel_cyc = -1; last_long_cyc = -1;
  endtask

  // One clock edge, then sample 1 ns later and tally events.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse === 1'b1) begin n_press++; last_press_cyc = cyc; end
    if (release_pulse === 1'b1) begin n_rel++; last_rel_cyc = cyc; end
    if (long_press_pulse === 1'b1) begin n_long++; last_long_cyc = cyc; end
    if (btn_level === 1'b1) level_hi++;
    if (press_pulse === 1'b1 && (release_pulse === 1'b1 || long_press_pulse === 1'b1)) overlap++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    clear_counts();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_in = 1'b1;
    clear_counts();
    repeat (12) step();
    vectors++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", btn_level); end
    vectors++;
    if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", press_count); end
    vectors++;
    if (n_press + n_rel + n_long !== 0) begin errors++; $display("FAIL reset_pulses: got %0d expected 0", n_press + n_rel + n_long); end
    vectors++;
    if (level_hi !== 0) begin errors++; $display("FAIL reset_level_held: got %0d high cycles expected 0", level_hi); end
    $display("test_reset: outputs held low during reset with button pressed");
    apply_reset();
  endtask

  task automatic test_clean_press();
    clear_counts();
    btn_in = 1'b1;
    repeat (10) step();
    vectors++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL press_early: got %b expected 0 at edge 9", btn_level); end
    step();
    vectors++;
    if (btn_level !== 1'b1 || press_pulse !== 1'b1) begin
      errors++; $display("FAIL press_edge10: got level=%b pulse=%b expected 1/1", btn_level, press_pulse);
    end
    repeat (4) step();
    vectors++;
    if (n_press !== 1) begin errors++; $display("FAIL press_pulse_width: got %0d expected 1", n_press); end
    vectors++;
    if (press_count !== 8'd1) begin errors++; $display("FAIL press_count1: got %0d expected 1", press_count); end
    vectors++;
    if (n_long !== 0) begin errors++; $display("FAIL press_no_long: got %0d expected 0", n_long); end
    $display("test_clean_press: press at edge %0d count %0d", last_press_cyc, press_count);
    btn_in = 1'b0;
    clear_counts();
    repeat (12) step();
    vectors++;
    if (last_rel_cyc !== 10 || n_rel !== 1) begin
      errors++; $display("FAIL release_latency: got edge %0d count %0d expected edge 10 count 1", last_rel_cyc, n_rel);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    btn_in = 1'b1; repeat (5) step();
    btn_in = 1'b0; repeat (3) step();
    btn_in = 1'b1; repeat (4) step();
    btn_in = 1'b0; repeat (20) step();
    vectors++;
    if (level_hi !== 0) begin errors++; $display("FAIL glitch_level: got %0d high cycles expected 0", level_hi); end
    vectors++;
    if (n_press + n_rel + n_long !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", n_press + n_rel + n_long); end
    vectors++;
    if (press_count !== 8'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", press_count); end
    $display("test_glitch: bounces rejected, count %0d", press_count);
  endtask

  task automatic test_long_press();
    clear_counts();
    btn_in = 1'b1;
    repeat (40) step();
    vectors++;
    if (last_press_cyc !== 10) begin errors++; $display("FAIL long_press_edge: got %0d expected 10", last_press_cyc); end
    vectors++;
    if (n_long !== 1 || last_long_cyc !== 30) begin
      errors++; $display("FAIL long_pulse: got count %0d edge %0d expected count 1 edge 30", n_long, last_long_cyc);
    end
    vectors++;
    if (overlap !== 0) begin errors++; $display("FAIL long_overlap: got %0d expected 0", overlap); end
    $display("test_long_press: press edge %0d long edge %0d", last_press_cyc, last_long_cyc);
    btn_in = 1'b0;
    clear_counts();
    repeat (12) step();
    vectors++;
    if (last_rel_cyc !== 10 || btn_level !== 1'b0) begin
      errors++; $display("FAIL long_release: got edge %0d level %b expected edge 10 level 0", last_rel_cyc, btn_level);
    end
    vectors++;
    if (n_long !== 0) begin errors++; $display("FAIL long_after_release: got %0d expected 0", n_long); end
  endtask

  task automatic test_release_bounce();
    clear_counts();
    btn_in = 1'b1; repeat (13) step();
    btn_in = 1'b0; repeat (4) step();
    btn_in = 1'b1; repeat (40) step();
    vectors++;
    if (n_rel !== 0 || n_press !== 1) begin
      errors++; $display("FAIL bounce_pulses: got press %0d release %0d expected 1/0", n_press, n_rel);
    end
    vectors++;
    if (level_hi !== 47) begin errors++; $display("FAIL bounce_level: got %0d high cycles expected 47", level_hi); end
    vectors++;
    // Hold paused for 5 edges (edges 15..19 not counting) so long fires at 35.
    if (n_long !== 1 || last_long_cyc !== 35) begin
      errors++; $display("FAIL bounce_long: got count %0d edge %0d expected count 1 edge 35", n_long, last_long_cyc);
    end
    $display("test_release_bounce: long edge %0d, no release", last_long_cyc);
    btn_in = 1'b0; repeat (12) step();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 256; i++) begin
      btn_in = 1'b1; repeat (12) step();
      $display("press %0d: count %0d", i, press_count);
      if (i == 255) begin
        vectors++;
        if (press_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", press_count); end
      end
      if (i == 256) begin
        vectors++;
        if (press_count !== 8'd0) begin errors++; $display("FAIL wrap_256: got %0d expected 0", press_count); end
      end
      btn_in = 1'b0; repeat (12) step();
    end
    vectors++;
    if (n_press !== 256 || n_rel !== 256) begin
      errors++; $display("FAIL wrap_pulses: got press %0d release %0d expected 256/256", n_press, n_rel);
    end
    vectors++;
    if (n_long !== 0 || overlap !== 0) begin
      errors++; $display("FAIL wrap_extra: got long %0d overlap %0d expected 0/0", n_long, overlap);
    end
  endtask

  task automatic test_reset_mid();
    // Reset in the middle of DB_PRESS.
    clear_counts();
    btn_in = 1'b1; repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0 || press_count !== 8'd0) begin
      errors++; $display("FAIL rst_dbpress: got lvl/pulses %b%b%b%b count %0d expected 0", btn_level, press_pulse, release_pulse, long_press_pulse, press_count);
    end
    repeat (3) step();
    rst_n = 1'b1;
    clear_counts();
    repeat (12) step();
    vectors++;
    if (last_press_cyc !== 10 || press_count !== 8'd1) begin
      errors++; $display("FAIL rst_repress1: got edge %0d count %0d expected 10/1", last_press_cyc, press_count);
    end
    // Reset while PRESSED; asynchronous so it is checked between edges.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (btn_level !== 1'b0 || press_count !== 8'd0) begin
      errors++; $display("FAIL rst_pressed: got level %b count %0d expected 0/0", btn_level, press_count);
    end
    clear_counts();
    repeat (4) step();
    vectors++;
    if (n_press + n_rel + n_long !== 0) begin errors++; $display("FAIL rst_pulses: got %0d expected 0", n_press + n_rel + n_long); end
    rst_n = 1'b1;
    clear_counts();
    repeat (12) step();
    vectors++;
    if (last_press_cyc !== 10 || press_count !== 8'd1 || n_press !== 1) begin
      errors++; $display("FAIL rst_repress2: got edge %0d count %0d pulses %0d expected 10/1/1", last_press_cyc, press_count, n_press);
    end
    $display("test_reset_mid: re-press after reset at edge %0d", last_press_cyc);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Input-side counterpart to the board's LED output blocks. Takes a raw, bouncy, asynchronous push-button pin and produces a clean debounced level plus single-cycle press, release and long-press event pulses. It also keeps a wrapping press counter. Sits directly behind the button pins on the 12 MHz CmodA7 clock domain and feeds user logic such as LED mode selection.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on btn_in; legal range 2..4.
DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept a level change (10 ms at 12 MHz); legal when >= 2.
LONG_PRESS_CYCLES, 6000000, cycles held in PRESSED before long_press_pulse fires (0.5 s at 12 MHz); legal when >= 2.
ACTIVE_HIGH, 1, 1 = pin reads 1 when pressed; 0 = pin is inverted at the input before synchronization.

Ports:
clk  input  1  system clock, 12 MHz
rst_n  input  1  asynchronous active-low reset
btn_in  input  1  raw button pin, asynchronous to clk
btn_level  output  1  debounced pressed level, 1 = pressed
press_pulse  output  1  one-cycle pulse when a press is accepted
release_pulse  output  1  one-cycle pulse when a release is accepted
long_press_pulse  output  1  one-cycle pulse, at most once per press
press_count  output  8  count of accepted presses, wraps 255 -> 0

Behaviour:
- Reset (rst_n low): takes effect immediately, independent of clk.
  - All synchronizer flops go to the not-pressed level (0 after polarity correction).
  - State goes to RELEASED.
  - Debounce counter, hold counter, long_done flag and every output go to 0.
- Synchronizer: btn_in is polarity-corrected per ACTIVE_HIGH, then passed through SYNC_STAGES flops. The last stage is "s".
- Counters: debounce counter is clog2(DEBOUNCE_CYCLES) bits; hold counter is clog2(LONG_PRESS_CYCLES) bits. Neither counter ever exceeds its terminal value.
- FSM states and transitions:
  - RELEASED: if s=1, go to DB_PRESS and clear the debounce counter.
  - DB_PRESS:
    - If s=0, return to RELEASED. No pulse; glitch rejected.
    - Else if counter = DEBOUNCE_CYCLES-1, go to PRESSED: btn_level<=1, press_pulse<=1, press_count<=press_count+1, hold counter<=0, long_done<=0.
    - Else increment the counter.
  - PRESSED:
    - If s=0, go to DB_RELEASE and clear the debounce counter.
    - Else if long_done=0: if hold counter = LONG_PRESS_CYCLES-1, then long_press_pulse<=1 and long_done<=1; otherwise increment the hold counter.
  - DB_RELEASE:
    - If s=1, return to PRESSED. No pulse; the hold counter keeps its value (paused, not cleared).
    - Else if counter = DEBOUNCE_CYCLES-1, go to RELEASED: btn_level<=0, release_pulse<=1.
    - Else increment the debounce counter.
- Pulse rules:
  - All pulse outputs are registered and high for exactly one cycle.
  - press_pulse and release_pulse are never high in the same cycle.
  - long_press_pulse never coincides with press_pulse.
- Latency:
  - Take edge 0 as the first rising edge sampling btn_in pressed.
  - With stable input, btn_level and press_pulse go high after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Release latency is identical.
  - long_press_pulse goes high LONG_PRESS_CYCLES edges after the press_pulse edge, provided no bounce occurs.
- Boundary conditions:
  - Bounce shorter than DEBOUNCE_CYCLES: produces no output change. Each bounce restarts the debounce count.
  - Release accepted before LONG_PRESS_CYCLES: no long_press_pulse for that press.
  - Hold far beyond LONG_PRESS_CYCLES: the hold counter freezes and no further long pulses fire.
  - press_count at 255: the next press sets it to 0.
  - Reset mid-debounce or while pressed: no pulses are emitted.
  - Button held through reset deassertion: treated as a new press, so press_pulse fires SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampling edge.

Test Plan:
(Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=20, ACTIVE_HIGH=1.)
1. Clean press: btn_in high from edge 0, held 15 cycles. Required: btn_level rises after edge 10; press_pulse high for exactly 1 cycle; press_count=1; no long_press_pulse.
2. Glitch rejection: btn_in high for 5 cycles, low for 3, high for 4, then low. Required: btn_level stays 0, no pulses, press_count=0.
3. Long press: hold btn_in high for 40 cycles. Required: long_press_pulse exactly once, 20 edges after press_pulse; no second long pulse. After release: release_pulse 10 edges after btn_in falls.
4. Release bounce: while pressed, drop btn_in for 4 cycles, then restore. Required: btn_level stays 1, no release_pulse, no extra press_pulse. Hold counter resumes and long_press_pulse still fires exactly once.
5. Wrap: 256 clean presses. Required: press_count reads 255 after the 255th press and 0 after the 256th; 256 press_pulses and 256 release_pulses.
6. Reset: assert rst_n low mid-DB_PRESS and again while PRESSED with btn_in held high. Required: all outputs go to 0 asynchronously, with no pulses. After deassertion with btn_in still high, press_pulse fires after edge 10 and press_count=1.
